// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding,
// next-PC source encoding and the default reset vector.
package aardvark_pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    PEND   = 2'd3
  } src_t;

  localparam logic [7:0] DEFAULT_RESET_VEC = 8'h00;

endpackage

// File: rtl/pc_redirect_latch.sv
// Single-entry holder for a redirect that arrived while the PC could not move.
// A capture always overwrites the entry; a consume empties it.
// The link fields carry the jump-and-link return address alongside the target.
module pc_redirect_latch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic             consume,
  input  logic [WIDTH-1:0] cap_target,
  input  logic             cap_link,
  input  logic [WIDTH-1:0] cap_link_addr,
  output logic             valid,
  output logic [WIDTH-1:0] target,
  output logic             link,
  output logic [WIDTH-1:0] link_addr
);

  // Hold, overwrite or drop the pending redirect entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      target    <= '0;
      link      <= 1'b0;
      link_addr <= '0;
    end else if (capture) begin
      valid     <= 1'b1;
      target    <= cap_target;
      link      <= cap_link;
      link_addr <= cap_link_addr;
    end else if (consume) begin
      valid     <= 1'b0;
      link      <= 1'b0;
    end else begin
      valid     <= valid;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC selection.
// Sources in priority order: live jump, live branch, pending redirect, pc+1.
// Optional feature macro: PC_LINK_REG_EN (jump-and-link return address in
// link_addr). Without it link_addr is tied to zero and jump_link is ignored.
module pc_sequencer
  import aardvark_pc_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEFAULT_RESET_VEC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_plus1_in,
  output logic [WIDTH-1:0] pc_out,
  output logic             fetch_req,
  input  logic             fetch_ack,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             halt,
  input  logic             resume,
  output logic             halted,
  output logic             pc_wrap,
  input  logic             jump_link,
  output logic [WIDTH-1:0] link_addr
);

  state_t           state;
  src_t             sel;
  logic             upd;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] next_pc;
  logic             capture;
  logic [WIDTH-1:0] cap_target;
  logic             cap_link;
  logic [WIDTH-1:0] cap_link_addr;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_target;
  logic             pend_link;
  logic [WIDTH-1:0] pend_link_addr;

  // The PC only moves when memory takes the fetch and nothing holds it
  assign upd = (state == FETCH) && fetch_ack && !stall;

  // Equal-width addition is the sign-extended add modulo 2^WIDTH
  assign branch_target = pc_out + branch_offset;

  // Next-PC source selection and pending-redirect capture
  always_comb begin
    sel     = SEQ;
    next_pc = pc_plus1_in;
    if (jump_en) begin
      sel     = JUMP;
      next_pc = jump_target;
    end else if (branch_taken) begin
      sel     = BRANCH;
      next_pc = branch_target;
    end else if (pend_valid) begin
      sel     = PEND;
      next_pc = pend_target;
    end else begin
      sel     = SEQ;
      next_pc = pc_plus1_in;
    end
    capture    = (state == FETCH) && (jump_en || branch_taken) && !upd;
    cap_target = jump_en ? jump_target : branch_target;
  end

`ifdef PC_LINK_REG_EN
  assign cap_link      = jump_en && jump_link;
  assign cap_link_addr = pc_plus1_in;

  // Return address latched when a linking jump (live or pending) is taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      link_addr <= '0;
    end else if (upd && (sel == JUMP) && jump_link) begin
      link_addr <= pc_plus1_in;
    end else if (upd && (sel == PEND) && pend_link) begin
      link_addr <= pend_link_addr;
    end else begin
      link_addr <= link_addr;
    end
  end
`else
  logic unused_link;
  assign cap_link      = 1'b0;
  assign cap_link_addr = '0;
  assign link_addr     = '0;
  assign unused_link   = jump_link ^ pend_link ^ (^pend_link_addr);
`endif

  pc_redirect_latch #(.WIDTH(WIDTH)) u_pend (
    .clk           (clk),
    .rst_n         (rst_n),
    .capture       (capture),
    .consume       (upd),
    .cap_target    (cap_target),
    .cap_link      (cap_link),
    .cap_link_addr (cap_link_addr),
    .valid         (pend_valid),
    .target        (pend_target),
    .link          (pend_link),
    .link_addr     (pend_link_addr)
  );

  // Sequencer FSM with registered PC, fetch request, halt flag and wrap pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc_out    <= RESET_VEC;
      fetch_req <= 1'b0;
      halted    <= 1'b0;
      pc_wrap   <= 1'b0;
    end else begin
      pc_wrap <= 1'b0;
      case (state)
        BOOT: begin
          state     <= FETCH;
          fetch_req <= 1'b1;
          halted    <= 1'b0;
        end
        FETCH: begin
          if (upd) begin
            pc_out  <= next_pc;
            pc_wrap <= (sel == SEQ) && (pc_out == {WIDTH{1'b1}});
          end
          if (halt) begin
            state     <= HALT;
            fetch_req <= 1'b0;
            halted    <= 1'b1;
          end else begin
            fetch_req <= 1'b1;
            halted    <= 1'b0;
          end
        end
        HALT: begin
          if (resume) begin
            state     <= FETCH;
            fetch_req <= 1'b1;
            halted    <= 1'b0;
          end else begin
            fetch_req <= 1'b0;
            halted    <= 1'b1;
          end
        end
        default: begin
          state     <= BOOT;
          fetch_req <= 1'b0;
          halted    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a vector table of inputs and the
// outputs expected one edge later, fed through a scoreboard queue, followed
// by a few hand-written multi-cycle sequences.
module tb_pc_sequencer;

  localparam int WIDTH = 8;
`ifdef PC_LINK_REG_EN
  localparam bit LINK_ON = 1'b1;
`else
  localparam bit LINK_ON = 1'b0;
`endif

  typedef struct {
    logic       rst_n, ack, stall, br;
    logic [7:0] off;
    logic       jmp;
    logic [7:0] tgt;
    logic       jl, hlt, res;
    logic [7:0] pc;
    logic       req, hd, wr;
    logic [7:0] lk;
  } vec_t;

  typedef struct {
    logic [7:0] pc;
    logic       req, hd, wr;
    logic [7:0] lk;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] pc_plus1_in, pc_out, branch_offset, jump_target, link_addr;
  logic             fetch_req, fetch_ack, stall, branch_taken, jump_en;
  logic             halt, resume, halted, pc_wrap, jump_link;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];
  exp_t sb[$];

  // Incrementer stage feeding the sequencer
  assign pc_plus1_in = pc_out + 8'd1;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pc_plus1_in(pc_plus1_in), .pc_out(pc_out),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_en(jump_en), .jump_target(jump_target), .halt(halt),
    .resume(resume), .halted(halted), .pc_wrap(pc_wrap),
    .jump_link(jump_link), .link_addr(link_addr)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, ack, st, br, input logic [7:0] off,
                     input logic jmp, input logic [7:0] tgt, input logic jl, hlt, res,
                     input logic [7:0] pc, input logic req, hd, wr, input logic [7:0] lk);
    vec_t v;
    v.rst_n = r; v.ack = ack; v.stall = st; v.br = br; v.off = off;
    v.jmp = jmp; v.tgt = tgt; v.jl = jl; v.hlt = hlt; v.res = res;
    v.pc = pc; v.req = req; v.hd = hd; v.wr = wr;
    v.lk = LINK_ON ? lk : 8'h00;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then compare the outputs after the edge
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n = v.rst_n; fetch_ack = v.ack; stall = v.stall; branch_taken = v.br;
    branch_offset = v.off; jump_en = v.jmp; jump_target = v.tgt;
    jump_link = v.jl; halt = v.hlt; resume = v.res;
    e.pc = v.pc; e.req = v.req; e.hd = v.hd; e.wr = v.wr; e.lk = v.lk;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"},     pc_out,           e.pc);
    chk({tag, ".req"},    {7'd0, fetch_req}, {7'd0, e.req});
    chk({tag, ".halted"}, {7'd0, halted},    {7'd0, e.hd});
    chk({tag, ".wrap"},   {7'd0, pc_wrap},   {7'd0, e.wr});
    chk({tag, ".link"},   link_addr,        e.lk);
  endtask

  initial begin
    vec_t v;
    logic [7:0] model_pc;
    int n;
    bit seen;
    rst_n = 1'b0; fetch_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_offset = 8'h00; jump_en = 1'b0; jump_target = 8'h00;
    jump_link = 1'b0; halt = 1'b0; resume = 1'b0;

    //   rst ack st br off   jmp tgt  jl h r    pc  req hd wr lk
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00); // reset
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00); // BOOT->FETCH
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h01, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h02, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h03, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 1, 8'h10, 0, 0, 0, 8'h10, 1, 0, 0, 8'h00); // to 10
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h10, 1, 0, 0, 8'h00); // no ack x3
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h10, 1, 0, 0, 8'h00);
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h10, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h11, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 1, 8'h10, 0, 0, 0, 8'h10, 1, 0, 0, 8'h00);
    add(1, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h10, 1, 0, 0, 8'h00); // stall
    add(1, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h10, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h11, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 1, 8'h05, 0, 0, 0, 8'h05, 1, 0, 0, 8'h00);
    add(1, 1, 0, 1, 8'hFD, 0, 8'h00, 0, 0, 0, 8'h02, 1, 0, 0, 8'h00); // back branch
    add(1, 1, 0, 0, 8'h00, 1, 8'hFF, 0, 0, 0, 8'hFF, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 1, 8'h00); // seq wrap
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h01, 1, 0, 0, 8'h00); // one pulse
    add(1, 1, 0, 0, 8'h00, 1, 8'hFE, 0, 0, 0, 8'hFE, 1, 0, 0, 8'h00);
    add(1, 1, 0, 1, 8'h04, 0, 8'h00, 0, 0, 0, 8'h02, 1, 0, 0, 8'h00); // branch wrap
    add(1, 1, 0, 0, 8'h00, 1, 8'h20, 0, 0, 0, 8'h20, 1, 0, 0, 8'h00);
    add(1, 0, 0, 0, 8'h00, 1, 8'h80, 0, 0, 0, 8'h20, 1, 0, 0, 8'h00); // capture
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h20, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h80, 1, 0, 0, 8'h00); // consume
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h81, 1, 0, 0, 8'h00);
    add(1, 1, 0, 1, 8'h10, 1, 8'h50, 0, 0, 0, 8'h50, 1, 0, 0, 8'h00); // jump wins
    add(1, 0, 0, 1, 8'h04, 0, 8'h00, 0, 0, 0, 8'h50, 1, 0, 0, 8'h00); // pend branch
    add(1, 0, 0, 0, 8'h00, 1, 8'hA0, 0, 0, 0, 8'h50, 1, 0, 0, 8'h00); // overwritten
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'hA0, 1, 0, 0, 8'h00);
    add(1, 0, 0, 0, 8'h00, 1, 8'h60, 0, 0, 0, 8'hA0, 1, 0, 0, 8'h00);
    add(1, 1, 0, 1, 8'h02, 0, 8'h00, 0, 0, 0, 8'hA2, 1, 0, 0, 8'h00); // live wins
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'hA3, 1, 0, 0, 8'h00); // pend cleared
    add(1, 0, 0, 1, 8'h10, 0, 8'h00, 0, 0, 0, 8'hA3, 1, 0, 0, 8'h00);
    add(1, 1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'hA3, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'hB3, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 1, 8'h30, 0, 0, 0, 8'h30, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h31, 0, 1, 0, 8'h00); // halt+upd
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h31, 0, 1, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 1, 8'h77, 0, 0, 0, 8'h31, 0, 1, 0, 8'h00); // ignored
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 1, 8'h31, 1, 0, 0, 8'h00); // resume wins
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h32, 1, 0, 0, 8'h00);
    add(1, 0, 0, 0, 8'h00, 1, 8'h44, 0, 1, 0, 8'h32, 0, 1, 0, 8'h00); // pend + halt
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h32, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h44, 1, 0, 0, 8'h00); // retained
    add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h44, 0, 1, 0, 8'h00);
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00); // reset in HALT
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 8'h00, 1, 0, 0, 8'h00); // halt in BOOT
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h01, 1, 0, 0, 8'h00);
    add(1, 0, 0, 0, 8'h00, 1, 8'h99, 0, 0, 0, 8'h01, 1, 0, 0, 8'h00);
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h01, 1, 0, 0, 8'h00); // pend gone
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 0, 8'h00); // stray resume
    add(1, 1, 0, 0, 8'h00, 1, 8'h40, 0, 0, 0, 8'h40, 1, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 1, 8'h90, 1, 0, 0, 8'h90, 1, 0, 0, 8'h41); // jump+link
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h91, 1, 0, 0, 8'h41);
    add(1, 0, 0, 0, 8'h00, 1, 8'hC0, 1, 0, 0, 8'h91, 1, 0, 0, 8'h41); // pend link
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'hC0, 1, 0, 0, 8'h92);
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    add(1, 1, 0, 0, 8'h00, 1, 8'h55, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00); // BOOT ignores
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h01, 1, 0, 0, 8'h00);

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Random hold/stall runs: PC must not move until an unstalled ack
    model_pc = 8'h01;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        v = vecs[0];
        v.rst_n = 1'b1; v.ack = 1'($urandom_range(0, 1)); v.stall = v.ack;
        v.pc = model_pc; v.req = 1'b1; v.hd = 1'b0; v.wr = 1'b0; v.lk = 8'h00;
        apply(v, $sformatf("hold%0d_%0d", r, k));
      end
      model_pc = model_pc + 8'd1;
      v.ack = 1'b1; v.stall = 1'b0; v.pc = model_pc;
      apply(v, $sformatf("go%0d", r));
    end

    // Halt, then resume and wait a bounded number of cycles for fetch_req
    v.hlt = 1'b1; v.ack = 1'b0; v.req = 1'b0; v.hd = 1'b1;
    apply(v, "halt_seq");
    @(negedge clk);
    halt = 1'b0; resume = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = fetch_req;
      resume = 1'b0;
    end
    chk("resume_timeout", {7'd0, seen}, 8'h01);
    chk("resume_pc", pc_out, model_pc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter register and next-PC selection stage that sits directly downstream of the PC incrementer.
- Consumes the incrementer's `pc+1` result and drives the current PC back to the incrementer and to instruction memory.
- Chooses between three next-PC sources: sequential (`pc+1`), branch redirect (PC-relative) and jump redirect (absolute).
- Handles the fetch request/acknowledge handshake, stall, halt/resume, and redirects that arrive while the PC cannot move.

Parameters:
- `WIDTH`, 8, PC/address width in bits.
- `RESET_VEC`, 8'h00, PC value loaded on reset.

Ports:
- `clk` in 1: system clock, all state updates on rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `pc_plus1_in` in WIDTH: incremented PC from the incrementer stage (`pc_out+1`).
- `pc_out` out WIDTH: current PC, to the incrementer and instruction memory.
- `fetch_req` out 1: fetch request to instruction memory.
- `fetch_ack` in 1: memory accepted the fetch at `pc_out` this cycle.
- `stall` in 1: hold PC even if `fetch_ack`.
- `branch_taken` in 1: PC-relative redirect request.
- `branch_offset` in WIDTH: signed two's-complement offset.
- `jump_en` in 1: absolute redirect request.
- `jump_target` in WIDTH: absolute target.
- `halt` in 1: enter halted state.
- `resume` in 1: leave halted state.
- `halted` out 1: high while in HALT.
- `pc_wrap` out 1: one-cycle pulse on a sequential wrap from all-ones to 0.

Behaviour:
- **Interface:** one clock; reset is synchronous and active-low. Clock port is `clk`, reset port is `rst_n`.
- **Reset** (`rst_n`=0 at an edge), same edge regardless of state:
  - `pc_out`=`RESET_VEC`, `fetch_req`=0, `halted`=0, `pc_wrap`=0.
  - Pending redirect cleared; state=BOOT.
- **States:** BOOT, FETCH, HALT.
- **BOOT:** `fetch_req`=0; unconditionally goes to FETCH next cycle. Redirect inputs are ignored.
- **FETCH:** `fetch_req`=1 (registered, high from the first FETCH cycle).
  - `fetch_req` stays high and `pc_out` stays stable until `fetch_ack`.
  - Update condition: `upd` = `fetch_ack` & !`stall`.
- **Next-PC priority** when `upd`:
  1. `jump_en` → `jump_target`.
  2. else `branch_taken` → `pc_out` + sign-extended `branch_offset`, modulo 2^WIDTH (no carry-out).
  3. else pending redirect → its target.
  4. else `pc_plus1_in`.
  - New PC is visible one cycle after the `upd` edge.
- **Pending redirect** (single entry):
  - Captured when `jump_en`/`branch_taken` is asserted in FETCH and !`upd`. The target is computed at capture time, from `pc_out` at that time.
  - A newer request overwrites the entry; a jump also overwrites a pending branch.
  - Consumed and cleared on the next `upd`.
  - A live redirect on the `upd` cycle overrides the pending one and also clears it.
- **HALT entry:** `halt`=1 in FETCH → HALT at the next edge.
  - If `upd` in the same cycle, the PC update still occurs.
  - In HALT: `fetch_req`=0, `halted`=1, PC frozen, the pending redirect is retained, and branch/jump inputs are ignored.
  - `halt` in BOOT is ignored.
- **HALT exit:** `resume`=1 → FETCH at the next edge. If `halt` and `resume` are both high in HALT, `resume` wins. `resume` outside HALT has no effect.
- **`pc_wrap`:** registered; asserted for one cycle after an `upd` edge that selected the sequential source with `pc_out`=all-ones. Redirects that cross zero do not pulse it.
- **Consistency:** `pc_plus1_in` is trusted as is; no internal re-increment.

Optional Feature:
- Macro: `PC_LINK_REG_EN`.
- **Defined:**
  - Adds input `jump_link` (1) and output `link_addr` (WIDTH), reset 0.
  - When a live `jump_en` with `jump_link` wins on an `upd` edge, `link_addr` <= `pc_plus1_in`.
  - A pending jump captures `jump_link` and `pc_plus1_in` with the target.
- **Not defined:** the ports still exist; `link_addr` is tied to 0 and `jump_link` is ignored.

Decomposition:
- **Shared package `aardvark_pc_pkg`:**
  - State encoding (BOOT=2'd0, FETCH=2'd1, HALT=2'd2).
  - Redirect-source encoding (SEQ, BRANCH, JUMP, PEND).
  - Default `RESET_VEC`.
- **Sub-module `pc_redirect_latch`:** the single-entry pending-redirect holder.
  - Inputs: capture, consume, target, link bit.
  - Outputs: valid, target, link bit.
- **Top level keeps:** the FSM, next-PC mux and `pc_wrap` logic.

Test Plan:
1. **Reset and sequential fetch.** Reset, then `fetch_ack`=1 every cycle → `fetch_req` 0 in BOOT; `pc_out` 00,01,02,03 on consecutive cycles after BOOT.
2. **Held fetch and stall.** `pc_out`=10, `fetch_ack`=0 for 3 cycles, then 1 → `pc_out` stays 10, `fetch_req` stays high, then 11. Repeat with `stall`=1 and `fetch_ack`=1 → `pc_out` holds 10.
3. **Branch and wrap.**
   - Backward branch: `pc_out`=05, `branch_taken` with offset 8'hFD (-3) on an `upd` cycle → `pc_out`=02.
   - Sequential wrap: `pc_out`=FF, sequential `upd` → `pc_out`=00 and a `pc_wrap` pulse of one cycle.
   - Wrapping branch: `pc_out`=FE, offset 8'h04 → `pc_out`=02 with `pc_wrap`=0.
4. **Pending redirect.** `pc_out`=20, `fetch_ack`=0; `jump_en` target 80 asserted for one cycle → captured. Later `fetch_ack`=1 with no live redirect → `pc_out`=80. Also: `jump_en` and `branch_taken` together on an `upd` cycle → jump target wins.
5. **Halt and resume.** `halt` with `fetch_ack`=1 at `pc_out`=30 → `pc_out`=31, `halted`=1, `fetch_req`=0. `halt`+`resume` together in HALT → back to FETCH. Reset asserted while in HALT → `pc_out`=00, BOOT.
6. **`PC_LINK_REG_EN` defined.** `jump_en`+`jump_link` at `pc_out`=40, target 90 → `pc_out`=90, `link_addr`=41.
   - Without the macro: `link_addr` stays 00.
